// File: rtl/soc_wb_pkg.sv
// Shared Wishbone B3 constants and types for the SoC bus slaves.
package soc_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StRburst
  } wb_bridge_state_e;

  // Beats per wrap block; 0 means linear (no wrap).
  function automatic int unsigned bte_beats(input logic [1:0] bte);
    case (bte)
      BTE_WRAP4:  return 4;
      BTE_WRAP8:  return 8;
      BTE_WRAP16: return 16;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/soc_wb2sram_bridge_if.sv
// Wishbone B3 slave-side bundle used by the WB-to-SRAM bridge.
interface soc_wb2sram_bridge_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  localparam int unsigned SW = DW / 8;

  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [SW-1:0] wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/soc_wb_burst_addr.sv
// Next beat address of a Wishbone incrementing burst: a + SW, wrapped inside an
// aligned 4/8/16-beat block according to BTE.
module soc_wb_burst_addr
  import soc_wb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned SW = 4
) (
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    bte_i,
  output logic [AW-1:0] next_o
);

  logic [AW-1:0] inc;
  logic [AW-1:0] mask;

  // Linear gives 0 beats, so the mask underflows to all ones and nothing wraps.
  always_comb begin
    inc    = addr_i + AW'(SW);
    mask   = AW'(bte_beats(bte_i) * SW) - AW'(1);
    next_o = (addr_i & ~mask) | (inc & mask);
  end

endmodule

// File: rtl/soc_wb2sram_bridge.sv
// Wishbone B3 slave to single-port SRAM bridge: one wait state for classic cycles,
// one beat per clock for incrementing read bursts, error on out-of-range addresses.
module soc_wb2sram_bridge
  import soc_wb_pkg::*;
#(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned MEM_SIZE_BYTE = 32'h8000,
  localparam int unsigned SW           = DW / 8,
  localparam int unsigned WORD_AW      = AW - $clog2(SW)
) (
  input  logic               clk,
  input  logic               rst,
  soc_wb2sram_bridge_if.slave wb,
  output logic               sram_ce,
  output logic               sram_we,
  output logic               sram_oe,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [DW-1:0]      sram_din,
  output logic [SW-1:0]      sram_sel,
  input  logic [DW-1:0]      sram_dout
);

  localparam int unsigned   OffW     = $clog2(SW);
  localparam logic [AW-1:0] MemLimit = AW'(MEM_SIZE_BYTE);

  wb_bridge_state_e state_q, state_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    exp_q, exp_d;

  logic          req;
  logic          adr_oor;
  logic          cnt_oor;
  logic          burst_go;
  logic          issue;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] nxt_src;
  logic [AW-1:0] nxt_addr;

  assign req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q & ~rst;
  assign adr_oor  = wb.wb_adr_i >= MemLimit;
  assign cnt_oor  = cnt_q >= MemLimit;
  assign nxt_src  = (state_q == StRburst) ? cnt_q : wb.wb_adr_i;

  // exp_q holds the address of the beat being acked; the master must still present it.
  assign burst_go = ack_q & wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_we_i & ~rst &
                    (wb.wb_cti_i != CTI_EOB) & (wb.wb_adr_i == exp_q) & ~cnt_oor;

  soc_wb_burst_addr #(
    .AW (AW),
    .SW (SW)
  ) u_burst_addr (
    .addr_i (nxt_src),
    .bte_i  (wb.wb_bte_i),
    .next_o (nxt_addr)
  );

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    issue      = 1'b0;
    issue_addr = wb.wb_adr_i;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (adr_oor) begin
            err_d = 1'b1;
          end else begin
            issue = 1'b1;
            ack_d = 1'b1;
            exp_d = wb.wb_adr_i;
            if (!wb.wb_we_i && wb.wb_cti_i == CTI_INCR) begin
              state_d = StRburst;
              cnt_d   = nxt_addr;
            end
          end
        end
      end
      StRburst: begin
        if (burst_go) begin
          issue      = 1'b1;
          issue_addr = cnt_q;
          ack_d      = 1'b1;
          exp_d      = cnt_q;
          cnt_d      = nxt_addr;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!wb.wb_cyc_i) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  assign sram_ce    = issue;
  assign sram_we    = issue & wb.wb_we_i;
  assign sram_oe    = sram_ce & ~sram_we;
  assign sram_waddr = WORD_AW'(issue_addr >> OffW);
  assign sram_din   = wb.wb_dat_i;
  assign sram_sel   = wb.wb_sel_i;

  assign wb.wb_dat_o = sram_dout;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_rty_o = 1'b0;

endmodule
